// File: rtl/float_mult_arbiter.sv
// float_mult_arbiter
//
// Round-robin arbiter and sequencer that lets NREQ clients share one
// combinational 8-bit float multiplier. One operand pair is accepted at a
// time. The pair is registered onto mult_a/mult_b, and the product is sampled
// one cycle later. The product is then returned on a response port, tagged
// with the index of the requester that owns it.
//
// Handshake rule (both sides): a transfer happens on the rising clock edge
// where valid and ready are both high. A valid source holds its payload
// stable until that edge. The arbiter never checks this.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid[NREQ]    per-requester operand-pair valid
//   req_a/req_b        packed operands, requester i at [8i+7:8i]
//   req_ready[NREQ]    one-hot accept, high only in IDLE
//   mult_a/mult_b      registered operands to the shared multiplier
//   mult_p             combinational product from the shared multiplier
//   rsp_valid/ready    response handshake
//   rsp_id             requester index owning rsp_product
//   rsp_product        captured product
//   busy               high whenever the sequencer is not IDLE
module float_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        mult_a,
  output logic [7:0]        mult_b,
  input  logic [7:0]        mult_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_product,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     mult_a_q, mult_a_d;
  logic [7:0]     mult_b_q, mult_b_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]     rsp_product_q, rsp_product_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [NREQ-1:0] grant_oh;
  logic           accept;

  // Round-robin search: the first valid requester at or above ptr, with
  // wrap to 0. Because the search always starts at ptr, the requester just
  // served moves to the back of the line.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_q) + off) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    grant_oh[grant_idx] = grant_found;
  end

  assign accept = (state_q == S_IDLE) && grant_found;

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_MUL;
      S_MUL:   state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. req_ready is also gated by rst_n so that no grant is shown
  // while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE)) req_ready = grant_oh;
    busy = (state_q != S_IDLE);
  end

  // Datapath next values. The operand registers keep their last values
  // after an operation. They are not cleared.
  always_comb begin
    ptr_d         = ptr_q;
    id_d          = id_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mult_a_d = req_a[int'(grant_idx)*8 +: 8];
          mult_b_d = req_b[int'(grant_idx)*8 +: 8];
          id_d     = grant_idx;
          ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      S_MUL: begin
        // mult_p has had one full cycle to settle from mult_a_q/mult_b_q.
        rsp_product_d = mult_p;
        rsp_id_d      = id_q;
        rsp_valid_d   = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      id_q          <= '0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

endmodule

// File: tb/tb_float_mult_arbiter.sv
// Testbench for float_mult_arbiter.
// A stub multiplier (mult_p = mult_a + mult_b) stands in for the real
// float multiplier. Each task handles one scenario. Inputs change 1 ns
// after a rising edge, and outputs are sampled 1 ns later.
module tb_float_mult_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mult_a;
  logic [7:0]        mult_b;
  logic [7:0]        mult_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_product;
  logic              busy;

  int n_vec;
  int n_err;

  // Scoreboard: {id, product} entries, in acceptance order.
  logic [IDW+7:0] exp_q[$];

  // Scratch variables shared by the tasks.
  logic [3:0]     exp_rdy;
  logic [IDW-1:0] exp_id;
  logic [7:0]     exp_p;
  logic [7:0]     hold_p;
  logic [IDW-1:0] hold_id;
  logic [IDW+7:0] sb_item;
  logic [3:0]     acc_mask;
  int             ptr_m;
  int             g;
  int             ops;
  bit             done;

  float_mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_p      (mult_p),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  assign mult_p = mult_a + mult_b;

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for one edge, then releases it. The caller is then in
  // window 0, where the first grant can be seen.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hf;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #2;
    n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready got %0h want 0", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    n_vec++; if ({mult_a, mult_b, rsp_product} !== 24'h0) begin n_err++; $display("FAIL reset_data got %0h want 0", {mult_a, mult_b, rsp_product}); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    req_a[7:0] = 8'h38;
    req_b[7:0] = 8'h40;
    rsp_ready  = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got %0b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_ready_mul got %0b want 0000", req_ready); end
    n_vec++; if ({mult_a, mult_b} !== 16'h3840) begin n_err++; $display("FAIL single_operands got %0h want 3840", {mult_a, mult_b}); end
    n_vec++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_mul_state got busy=%0b rsp_valid=%0b want 1,0", busy, rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid got %0b want 1", rsp_valid); end
    n_vec++; if (rsp_product !== 8'h78) begin n_err++; $display("FAIL single_product got %0h want 78", rsp_product); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp_id got %0d want 0", rsp_id); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_done got rsp_valid=%0b busy=%0b want 0,0", rsp_valid, busy); end
    n_vec++; if ({mult_a, mult_b} !== 16'h3840) begin n_err++; $display("FAIL single_operands_hold got %0h want 3840", {mult_a, mult_b}); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'h10 * i[7:0] + 8'h01;
      req_b[8*i +: 8] = 8'h20 + i[7:0];
    end
    req_valid = 4'hf;
    rsp_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      #1;
      exp_id = 2'((k / 3) % NREQ);
      exp_rdy = (k % 3 == 0) ? (4'b0001 << exp_id) : 4'b0000;
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant k=%0d got %0b want %0b", k, req_ready, exp_rdy); end
      if (k % 3 == 2) begin
        exp_p = (8'h10 * {6'd0, exp_id} + 8'h01) + (8'h20 + {6'd0, exp_id});
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_product !== exp_p) begin
          n_err++; $display("FAIL rr_rsp k=%0d got v=%0b id=%0d p=%0h want 1 %0d %0h", k, rsp_valid, rsp_id, rsp_product, exp_id, exp_p);
        end
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_a[7:0]  = 8'h3a; req_b[7:0]  = 8'h41;
    req_a[15:8] = 8'h05; req_b[15:8] = 8'h06;
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_grant got %0b want 0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    tick();
    hold_p  = rsp_product;
    hold_id = rsp_id;
    n_vec++; if (rsp_valid !== 1'b1 || hold_p !== 8'h7b || hold_id !== 2'd0) begin
      n_err++; $display("FAIL bp_rsp got v=%0b id=%0d p=%0h want 1 0 7b", rsp_valid, hold_id, hold_p);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 8'h7b) begin
        n_err++; $display("FAIL bp_hold k=%0d got v=%0b id=%0d p=%0h want 1 0 7b", k, rsp_valid, rsp_id, rsp_product);
      end
      n_vec++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin
        n_err++; $display("FAIL bp_idle k=%0d got ready=%0b busy=%0b want 0000 1", k, req_ready, busy);
      end
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got %0b want 0", rsp_valid); end
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_next_grant got %0b want 0010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] valids [4];
    logic [3:0] grants [4];
    valids = '{4'b1000, 4'b1010, 4'b1010, 4'b0011};
    grants = '{4'b1000, 4'b0010, 4'b1000, 4'b0001};
    do_reset();
    rsp_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      req_valid = valids[s];
      #1;
      n_vec++; if (req_ready !== grants[s]) begin n_err++; $display("FAIL wrap_grant step=%0d got %0b want %0b", s, req_ready, grants[s]); end
      tick();
      req_valid = '0;
      tick();
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req_a[23:16] = 8'h11;
    req_b[23:16] = 8'h22;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b1 || mult_a !== 8'h11) begin n_err++; $display("FAIL mid_in_mul got busy=%0b a=%0h want 1 11", busy, mult_a); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({busy, rsp_valid, req_ready} !== 6'b0) begin n_err++; $display("FAIL mid_reset_ctl got %0b want 0", {busy, rsp_valid, req_ready}); end
    n_vec++; if ({mult_a, mult_b, rsp_product, rsp_id} !== 26'h0) begin n_err++; $display("FAIL mid_reset_data got %0h want 0", {mult_a, mult_b, rsp_product, rsp_id}); end
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_rsp k=%0d got %0b want 0", k, rsp_valid); end
    end
    // A ptr left at 3 would pick requester 3. After reset, ptr is 0 and
    // requester 0 wins.
    req_valid = 4'b1001;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr_zero got %0b want 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    exp_q.delete();
    ptr_m    = 0;
    ops      = 0;
    acc_mask = '0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      req_valid = req_valid & ~acc_mask;
      if (ops >= 1000 && req_valid == 0 && exp_q.size() == 0 && !busy) begin
        done = 1'b1;
      end else begin
        if (ops < 1000) begin
          for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
              req_valid[i]    = 1'b1;
              req_a[8*i +: 8] = 8'($urandom_range(0, 255));
              req_b[8*i +: 8] = 8'($urandom_range(0, 255));
            end
          end
        end
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        if ($countones(req_ready) > 1) begin n_vec++; n_err++; $display("FAIL rnd_onehot got %0b", req_ready); end
        if (rsp_valid && req_ready != 0) begin n_vec++; n_err++; $display("FAIL rnd_grant_in_resp got %0b want 0000", req_ready); end
        acc_mask = req_ready & req_valid;
        if (acc_mask != 0) begin
          g = -1;
          for (int off = 0; off < NREQ; off++) begin
            if (g < 0 && req_valid[(ptr_m + off) % NREQ]) g = (ptr_m + off) % NREQ;
          end
          n_vec++; if (acc_mask !== (4'b0001 << g)) begin n_err++; $display("FAIL rnd_arb got %0b want %0b", acc_mask, 4'b0001 << g); end
          exp_p = req_a[8*g +: 8] + req_b[8*g +: 8];
          exp_id = 2'(g);
          exp_q.push_back({exp_id, exp_p});
          ptr_m = (g + 1) % NREQ;
          ops++;
        end
        if (rsp_valid && rsp_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL rnd_extra_rsp got id=%0d p=%0h want none", rsp_id, rsp_product);
          end else begin
            sb_item = exp_q.pop_front();
            if ({rsp_id, rsp_product} !== sb_item) begin
              n_err++; $display("FAIL rnd_rsp got id=%0d p=%0h want id=%0d p=%0h", rsp_id, rsp_product, sb_item[9:8], sb_item[7:0]);
            end
          end
        end
        tick();
      end
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL rnd_timeout got ops=%0d pending=%0d want drained", ops, exp_q.size()); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_ptr_wrap();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
